// File: rtl/mod_exp_unit_pkg.sv
// Shared definitions for the modular exponentiation unit: FSM encoding,
// default widths and the results reported for degenerate moduli.
package mod_exp_unit_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int E_WIDTH_DEF = 65;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_MUL    = 3'd3,
        ST_SQR    = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    // Anything mod 0 is undefined (flagged via err), anything mod 1 is 0.
    localparam int unsigned RES_N_ZERO = 0;
    localparam int unsigned RES_N_ONE  = 0;

endpackage

// File: rtl/mod_exp_unit_mult.sv
// Serial modular multiplier: p = a*b mod n, interleaved shift-add over b
// MSB-first, one bit per cycle; done pulses WIDTH+1 cycles after start.
module mod_mult
    import mod_exp_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] p_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, n_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;

    logic [WIDTH+1:0] sum, sub1, sub2;
    logic [WIDTH-1:0] r_step;

    // 2r + a < 3n when r, a < n, so two conditional subtractions suffice.
    always_comb begin
        sum    = {1'b0, r_q, 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
        sub1   = (sum  >= {2'b00, n_q}) ? sum  - {2'b00, n_q} : sum;
        sub2   = (sub1 >= {2'b00, n_q}) ? sub1 - {2'b00, n_q} : sub1;
        r_step = sub2[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            n_q    <= n_i;
            r_q    <= '0;
            cnt_q  <= CW'(WIDTH);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            r_q    <= r_step;
            b_q    <= b_q << 1;
            cnt_q  <= cnt_q - CW'(1);
            run_q  <= (cnt_q != CW'(1));
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign p_o    = r_q;
    assign done_o = done_q;

endmodule

// File: rtl/mod_exp_unit.sv
// Right-to-left square-and-multiply modular exponentiation: result = base^e mod n,
// using a single shared serial modular multiplier.
//
// state  | meaning
// IDLE   | waiting for start with e_valid
// REDUCE | pow = base mod n, acc = 1
// CHECK  | inspect exponent LSB / zero
// MUL    | acc = acc*pow mod n
// SQR    | pow = pow*pow mod n, e >>= 1
// FINISH | result valid, done pulse
module mod_exp_unit
    import mod_exp_unit_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int E_WIDTH = E_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [E_WIDTH-1:0] e,
    input  logic               e_valid,
    input  logic [WIDTH-1:0]   base,
    input  logic [WIDTH-1:0]   n,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic               busy,
    output logic               err
);

    state_e             state_q, state_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]   base_q, base_d, n_q, n_d;
    logic [WIDTH-1:0]   acc_q, acc_d, pow_q, pow_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic               mm_wait_q, mm_wait_d;

    logic               mm_state, mm_start, mm_done;
    logic [WIDTH-1:0]   mm_a, mm_b, mm_p;

    mod_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mm_start),
        .a_i     (mm_a),
        .b_i     (mm_b),
        .n_i     (n_q),
        .p_o     (mm_p),
        .done_o  (mm_done)
    );

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        base_d    = base_q;
        n_d       = n_q;
        acc_d     = acc_q;
        pow_d     = pow_q;
        result_d  = result_q;
        err_d     = err_q;
        mm_a      = acc_q;
        mm_b      = pow_q;

        // Each multiplier state issues exactly one operation, then waits for done.
        mm_state  = (state_q == ST_REDUCE) || (state_q == ST_MUL) || (state_q == ST_SQR);
        mm_start  = mm_state && !mm_wait_q;
        mm_wait_d = mm_wait_q;
        if (mm_start)     mm_wait_d = 1'b1;
        else if (mm_done) mm_wait_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && e_valid) begin
                    e_d    = e;
                    base_d = base;
                    n_d    = n;
                    err_d  = 1'b0;
                    if (n == '0) begin
                        result_d = WIDTH'(RES_N_ZERO);
                        err_d    = 1'b1;
                        state_d  = ST_FINISH;
                    end else if (n == WIDTH'(1)) begin
                        result_d = WIDTH'(RES_N_ONE);
                        state_d  = ST_FINISH;
                    end else begin
                        state_d  = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                mm_a = WIDTH'(1);
                mm_b = base_q;
                if (mm_done) begin
                    pow_d   = mm_p;
                    acc_d   = WIDTH'(1);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (e_q == '0) begin
                    result_d = acc_q;
                    state_d  = ST_FINISH;
                end else if (e_q[0]) begin
                    state_d  = ST_MUL;
                end else begin
                    state_d  = ST_SQR;
                end
            end
            ST_MUL: begin
                mm_a = acc_q;
                mm_b = pow_q;
                if (mm_done) begin
                    acc_d   = mm_p;
                    state_d = ST_SQR;
                end
            end
            ST_SQR: begin
                mm_a = pow_q;
                mm_b = pow_q;
                if (mm_done) begin
                    pow_d   = mm_p;
                    e_d     = e_q >> 1;
                    state_d = ST_CHECK;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            e_q       <= '0;
            base_q    <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            pow_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            mm_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            base_q    <= base_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            pow_q     <= pow_d;
            result_q  <= result_d;
            err_q     <= err_d;
            mm_wait_q <= mm_wait_d;
        end
    end

    assign result = result_q;
    assign err    = err_q;
    assign done   = (state_q == ST_FINISH);
    assign busy   = (state_q != ST_IDLE);

endmodule
